// File: rtl/sram_stream_reader_pkg.sv
// Shared definitions for the SRAM read-stream sequencer: FSM encoding and
// the MAC-wide data/address width defaults.
package sram_stream_reader_pkg;

  localparam int unsigned MAC_BW = 32;
  localparam int unsigned MAC_AW = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_FIN
  } rd_state_t;

endpackage

// File: rtl/sram_stream_reader_fifo.sv
// Small synchronous FIFO buffering SRAM read data ahead of the output stream;
// the head word is presented combinationally.
module stream_fifo
  import sram_stream_reader_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned BW    = MAC_BW
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         push,
  input  logic [BW-1:0]                push_data,
  input  logic                         pop,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [BW-1:0]                head
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [BW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_stream_reader.sv
// Issues LEN consecutive SRAM reads from BASE and presents the returned words
// as a valid/ready stream with a last marker and a completion pulse.
module sram_stream_reader
  import sram_stream_reader_pkg::*;
#(
  parameter int unsigned BW         = MAC_BW,
  parameter int unsigned AW         = MAC_AW,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [AW-1:0] BASE,
  input  logic [AW:0]   LEN,
  output logic          BUSY,
  output logic          DONE,
  output logic          MEM_CSN,
  output logic          MEM_WEN,
  output logic [AW-1:0] MEM_A,
  input  logic [BW-1:0] MEM_DOUT,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [BW-1:0] OUT_DATA,
  output logic          OUT_LAST
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  rd_state_t     state;
  rd_state_t     state_nx;
  logic [AW:0]   len_q;
  logic [AW:0]   issued;
  logic [AW:0]   out_idx;
  logic          inflight;
  logic          issue;
  logic          pop;
  logic          start_ok;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occupancy;

  stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .BW    (BW)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (inflight),
    .push_data (MEM_DOUT),
    .pop       (pop),
    .count     (fifo_count),
    .head      (OUT_DATA)
  );

  assign OUT_VALID = (fifo_count != '0);
  assign pop       = OUT_VALID & OUT_READY;
  // Buffer fill after this cycle; a pop implies a buffered word, so no underflow.
  assign occupancy = {1'b0, fifo_count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue     = (state == ST_RUN) && (issued < len_q) &&
                     (occupancy < (CW+1)'(FIFO_DEPTH));
  assign MEM_CSN   = ~issue;
  assign MEM_WEN   = 1'b1;
  assign OUT_LAST  = OUT_VALID && (out_idx == len_q - 1'b1);
  assign BUSY      = (state == ST_RUN) || (state == ST_DRAIN);
  assign DONE      = (state == ST_FIN);
  assign start_ok  = (state == ST_IDLE) && START;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (START) state_nx = (LEN == '0) ? ST_FIN : ST_RUN;
      ST_RUN:   if (issued == len_q) state_nx = ST_DRAIN;
      ST_DRAIN: if (pop && OUT_LAST) state_nx = ST_FIN;
      ST_FIN:   state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      MEM_A    <= '0;
      len_q    <= '0;
      issued   <= '0;
      out_idx  <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_nx;
      inflight <= issue;
      if (start_ok) begin
        MEM_A   <= BASE;
        len_q   <= LEN;
        issued  <= '0;
        out_idx <= '0;
      end else begin
        if (issue) begin
          MEM_A  <= MEM_A + 1'b1;
          issued <= issued + 1'b1;
        end
        if (pop) out_idx <= out_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_stream_reader.sv
// Bench for sram_stream_reader: transaction-level model of the read stream
// checked every cycle, plus directed literal scenarios and a small AW=3 instance.
module tb_sram_stream_reader;

  localparam int DEPTH = 2;
  localparam longint NEVER = 64'h3fff_ffff_ffff_ffff;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ordy = 1'b1;
  logic [9:0]  base = '0;
  logic [10:0] len = '0;
  logic        busy, done, csn, wen, ov, ol;
  logic [9:0]  a;
  logic [31:0] dout = '0;
  logic [31:0] od;

  logic        start3 = 1'b0;
  logic        ordy3 = 1'b1;
  logic [2:0]  base3 = '0;
  logic [3:0]  len3 = '0;
  logic        busy3, done3, csn3, wen3, ov3, ol3;
  logic [2:0]  a3;
  logic [15:0] dout3 = '0;
  logic [15:0] od3;

  int checks = 0;
  int failures = 0;

  sram_stream_reader #(.BW(32), .AW(10), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(clk), .RST(rst), .START(start), .BASE(base), .LEN(len),
    .BUSY(busy), .DONE(done), .MEM_CSN(csn), .MEM_WEN(wen), .MEM_A(a),
    .MEM_DOUT(dout), .OUT_VALID(ov), .OUT_READY(ordy), .OUT_DATA(od),
    .OUT_LAST(ol)
  );

  sram_stream_reader #(.BW(16), .AW(3), .FIFO_DEPTH(2)) dut3 (
    .CLK(clk), .RST(rst), .START(start3), .BASE(base3), .LEN(len3),
    .BUSY(busy3), .DONE(done3), .MEM_CSN(csn3), .MEM_WEN(wen3), .MEM_A(a3),
    .MEM_DOUT(dout3), .OUT_VALID(ov3), .OUT_READY(ordy3), .OUT_DATA(od3),
    .OUT_LAST(ol3)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ramf(input logic [9:0] ad);
    return 32'h100 + 32'(ad);
  endfunction

  function automatic logic [15:0] ram3f(input logic [2:0] ad);
    return 16'h0A00 + 16'(ad);
  endfunction

  // Synchronous SRAMs with one-cycle read latency
  always @(posedge clk) if (!csn) dout <= ramf(a);
  always @(posedge clk) if (!csn3) dout3 <= ram3f(a3);

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model of the main instance ----------------
  longint      cyc = 0;
  longint      acc_cyc = 0;
  longint      done_cyc = NEVER;
  bit          active = 1'b0;
  int          outstanding = 0;
  logic [31:0] exp_data[$];
  logic [9:0]  exp_addr[$];
  longint      issue_cycs[$];
  bit          stall_prev = 1'b0;
  logic [31:0] prev_od = '0;
  logic [31:0] got_log[$];
  logic [9:0]  issue_log[$];
  int          done_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    bit ov_e, pop_e, iss_e;
    if (rst) begin
      active = 1'b0;
      outstanding = 0;
      exp_data.delete();
      exp_addr.delete();
      issue_cycs.delete();
      done_cyc = NEVER;
      stall_prev = 1'b0;
    end else begin
      // a word read in cycle k is at the head no earlier than cycle k+2
      ov_e  = (issue_cycs.size() > 0) && (issue_cycs[0] + 2 <= cyc);
      pop_e = ov_e && ordy;
      iss_e = active && (exp_addr.size() > 0) && (cyc > acc_cyc) &&
              (outstanding + 1 - int'(pop_e) <= DEPTH);
      chk("mem_wen", wen, 1);
      chk("mem_csn", csn, !iss_e);
      if (!csn) begin
        issue_log.push_back(a);
        chk("occupancy", (outstanding + 1 - int'(pop_e)) <= DEPTH, 1);
      end
      if (iss_e) begin
        chk("mem_a", a, exp_addr.pop_front());
        outstanding++;
        issue_cycs.push_back(cyc);
      end
      if (stall_prev) begin
        chk("stall_valid", ov, 1);
        chk("stall_data", od, prev_od);
      end
      chk("out_valid", ov, ov_e);
      if (ov_e) begin
        chk("out_data", od, exp_data[0]);
        chk("out_last", ol, exp_data.size() == 1);
      end else begin
        chk("out_last_idle", ol, 0);
      end
      if (pop_e) begin
        got_log.push_back(od);
        if (exp_data.size() == 1) done_cyc = cyc + 1;
        void'(exp_data.pop_front());
        void'(issue_cycs.pop_front());
        outstanding--;
      end
      chk("done", done, cyc == done_cyc);
      chk("busy", busy, active && (cyc > acc_cyc) && (cyc < done_cyc));
      if (done) done_count++;
      stall_prev = ov_e && !ordy;
      prev_od = od;
      if (active && cyc == done_cyc) begin
        active = 1'b0;
      end else if (start && !active) begin
        active  = 1'b1;
        acc_cyc = cyc;
        done_cyc = (len == 0) ? cyc + 1 : NEVER;
        for (int i = 0; i < int'(len); i++) begin
          exp_addr.push_back(10'(int'(base) + i));
          exp_data.push_back(ramf(10'(int'(base) + i)));
        end
      end
    end
  end

  // ---------------- observation of the AW=3 instance ----------------
  logic [2:0]  a3_log[$];
  logic [15:0] d3_log[$];
  logic        l3_log[$];
  int          done3_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (!csn3) a3_log.push_back(a3);
      if (ov3 && ordy3) begin
        d3_log.push_back(od3);
        l3_log.push_back(ol3);
      end
      if (done3) done3_cnt++;
    end
  end

  // ---------------- ready driver ----------------
  int rdy_mode = 0;
  int pat_idx = 0;
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      1: ordy = 1'($urandom_range(0, 1));
      2: begin
        ordy = (pat_idx < 4) ? ((pat_idx == 0) || (pat_idx == 3)) : 1'($urandom_range(0, 1));
        pat_idx++;
      end
      default: ordy = 1'b1;
    endcase
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cmd(input logic [9:0] b, input logic [10:0] l);
    base = b;
    len = l;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (active && n < budget) begin
      tick(1);
      n++;
    end
    chk("idle_timeout", active, 0);
    chk("stream_drained", exp_data.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_csn"}, csn, 1);
    chk({tag, "_wen"}, wen, 1);
    chk({tag, "_addr"}, a, 0);
    chk({tag, "_valid"}, ov, 0);
    chk({tag, "_data"}, od, 0);
    chk({tag, "_last"}, ol, 0);
  endtask

  logic [31:0] exp1 [5] = '{32'h104, 32'h105, 32'h106, 32'h107, 32'h108};
  logic [2:0]  exp3a [4] = '{3'd6, 3'd7, 3'd0, 3'd1};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n, dc, dc3;
    tick(2);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick(2);

    // Basic stream, BASE=4 LEN=5, ready held high
    rdy_mode = 0;
    base = 10'd4;
    len = 11'd5;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("t1_first_issue", csn, 0);
    k = 0;
    while (!ov && k < 10) begin
      tick(1);
      k++;
    end
    chk("t1_valid_latency", k, 2);
    for (int i = 0; i < 5; i++) begin
      chk("t1_valid", ov, 1);
      chk("t1_data", od, exp1[i]);
      chk("t1_last", ol, i == 4);
      tick(1);
    end
    chk("t1_done", done, 1);
    chk("t1_busy_fall", busy, 0);
    tick(1);
    chk("t1_done_pulse", done, 0);
    tick(2);

    // Backpressure pattern 1,0,0,1,random plus an ignored START during RUN
    rdy_mode = 2;
    pat_idx = 0;
    got_log.delete();
    dc = done_count;
    cmd(10'd4, 11'd5);
    tick(3);
    cmd(10'd100, 11'd3);
    wait_idle(100);
    chk("t2_count", got_log.size(), 5);
    if (got_log.size() == 5)
      for (int i = 0; i < 5; i++) chk("t2_word", got_log[i], 32'h104 + 32'(i));
    chk("t2_done_once", done_count - dc, 1);
    tick(2);

    // LEN = 0
    rdy_mode = 0;
    tick(1);
    issue_log.delete();
    got_log.delete();
    base = 10'd7;
    len = 11'd0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("len0_done", done, 1);
    chk("len0_csn", csn, 1);
    chk("len0_valid", ov, 0);
    tick(1);
    chk("len0_done_pulse", done, 0);
    tick(3);
    chk("len0_no_access", issue_log.size(), 0);
    chk("len0_no_word", got_log.size(), 0);

    // Full sweep with wrap, MEM_A returns to BASE
    issue_log.delete();
    got_log.delete();
    cmd(10'd3, 11'd1024);
    wait_idle(1300);
    chk("sweep_issues", issue_log.size(), 1024);
    chk("sweep_words", got_log.size(), 1024);
    if (got_log.size() == 1024) begin
      chk("sweep_word_top", got_log[1020], 32'h4FF);
      chk("sweep_word_wrap", got_log[1021], 32'h100);
    end
    chk("sweep_addr_return", a, 3);

    // AW=3 instance: BASE=6 LEN=4 wraps 6,7,0,1
    a3_log.delete();
    d3_log.delete();
    l3_log.delete();
    dc3 = done3_cnt;
    base3 = 3'd6;
    len3 = 4'd4;
    start3 = 1'b1;
    tick(1);
    start3 = 1'b0;
    n = 0;
    while (done3_cnt == dc3 && n < 40) begin
      tick(1);
      n++;
    end
    chk("aw3_done", done3_cnt - dc3, 1);
    chk("aw3_issues", a3_log.size(), 4);
    chk("aw3_words", d3_log.size(), 4);
    if (a3_log.size() == 4 && d3_log.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("aw3_addr", a3_log[i], exp3a[i]);
        chk("aw3_data", d3_log[i], ram3f(exp3a[i]));
        chk("aw3_last", l3_log[i], i == 3);
      end
    chk("aw3_wen", wen3, 1);
    tick(2);

    // AW=3 full sweep from BASE=5
    a3_log.delete();
    d3_log.delete();
    l3_log.delete();
    dc3 = done3_cnt;
    base3 = 3'd5;
    len3 = 4'd8;
    start3 = 1'b1;
    tick(1);
    start3 = 1'b0;
    n = 0;
    while (done3_cnt == dc3 && n < 60) begin
      tick(1);
      n++;
    end
    chk("aw3s_done", done3_cnt - dc3, 1);
    chk("aw3s_words", d3_log.size(), 8);
    if (a3_log.size() == 8 && d3_log.size() == 8)
      for (int i = 0; i < 8; i++) begin
        chk("aw3s_addr", a3_log[i], (5 + i) % 8);
        chk("aw3s_data", d3_log[i], 16'h0A00 + 16'((5 + i) % 8));
      end
    chk("aw3s_addr_return", a3, 5);
    tick(2);

    // Reset in the cycle after the third issue of LEN=8
    rdy_mode = 1;
    issue_log.delete();
    dc = done_count;
    cmd(10'd0, 11'd8);
    n = 0;
    while (issue_log.size() < 3 && n < 50) begin
      tick(1);
      n++;
    end
    chk("rst_third_issue", issue_log.size(), 3);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    tick(2);
    chk("midrst_no_done", done, 0);
    rst = 1'b0;
    tick(1);
    chk("midrst_done_count", done_count - dc, 0);
    rdy_mode = 0;
    tick(1);
    got_log.delete();
    cmd(10'd0, 11'd2);
    wait_idle(50);
    chk("postrst_count", got_log.size(), 2);
    if (got_log.size() == 2) begin
      chk("postrst_w0", got_log[0], 32'h100);
      chk("postrst_w1", got_log[1], 32'h101);
    end
    chk("postrst_done", done_count - dc, 1);
    tick(2);

    // Randomized commands with stalls and stray START pulses
    rdy_mode = 1;
    for (int r = 0; r < 16; r++) begin
      cmd(10'($urandom_range(0, 1023)), (r == 5) ? 11'd1 : 11'($urandom_range(0, 12)));
      if ($urandom_range(0, 2) == 0) begin
        tick($urandom_range(0, 3));
        cmd(10'($urandom_range(0, 1023)), 11'($urandom_range(0, 6)));
      end
      wait_idle(400);
      tick($urandom_range(0, 2));
    end

    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
